datamover_s2mm_feeder: RTL and testbench
========================================

DATAMOVER_S2MM_FEEDER -- requirements
Module: datamover_s2mm_feeder

Interface
Parameters (name, default, meaning):
REQ-001 BASE_ADDR, 32'h0000_0000, byte address of frame 0 in BRAM.
REQ-002 FRAME_BYTES, 4096, bytes per frame; a multiple of 4, from 4 to 2^23-4.
REQ-003 NUM_FRAMES, 4, frames per run; from 1 to 65535.

Ports (name, direction, width, meaning):
REQ-004 clk_in1  in  1  sole clock; all logic rising-edge.
REQ-005 aresetn  in  1  reset, asynchronous assert, active-low.
REQ-006 start_i  in  1  run request; sampled only in IDLE.
REQ-007 busy_o  out  1  high in every state except IDLE.
REQ-008 done_o  out  1  one-cycle pulse at end of run.
REQ-009 err_o  out  1  sticky error flag, cleared on next accepted start_i.
REQ-010 frame_cnt_o  out  16  frames completed in the current run.
REQ-011 m_axis_cmd_tdata  out  72  S2MM DataMover command.
REQ-012 m_axis_cmd_tvalid  out  1 / m_axis_cmd_tready  in  1  command handshake.
REQ-013 m_axis_data_tdata  out  32 / m_axis_data_tkeep  out  4 / m_axis_data_tlast  out  1 / m_axis_data_tvalid  out  1 / m_axis_data_tready  in  1  S2MM write-data stream.
REQ-014 s_axis_sts_tdata  in  8 / s_axis_sts_tvalid  in  1 / s_axis_sts_tready  out  1  S2MM status stream.

Function
REQ-015 The FSM states SHALL be IDLE, CMD, DATA, STS and DONE.
REQ-016 IDLE->CMD on start_i=1: frame index, word counter and frame_cnt_o cleared to 0, err_o cleared.
REQ-017 Command fields for frame n: BTT[22:0]=FRAME_BYTES; TYPE[23]=1; DSA[29:24]=0; EOF[30]=1; DRR[31]=0; SADDR[63:32]=BASE_ADDR+n*FRAME_BYTES (32-bit wrap); TAG[67:64]=n[3:0]; [71:68]=0.
REQ-018 CMD: tvalid held high with tdata stable until tready; handshake cycle -> DATA.
REQ-019 DATA: word k of the run carries tdata=k (32-bit run-wide counter, wraps at 2^32, does not restart per frame); tkeep=4'hF.
REQ-020 tdata/tvalid/tlast SHALL be stable while tvalid=1 and tready=0; the word counter advances only on a tvalid&tready cycle.
REQ-021 tlast=1 only on word FRAME_BYTES/4-1 of each frame; its handshake -> STS; FRAME_BYTES=4 gives a single beat with tlast=1.
REQ-022 tvalid=1 for every DATA cycle (no self-inserted bubbles); the data stream is never driven before that frame's command handshake.
REQ-023 STS: s_axis_sts_tready=1 (0 in every other state); on sts tvalid, latch the status byte and increment frame_cnt_o.
REQ-024 Status is an error if bit7 (OKAY)=0, any of bits 6:4 =1, or TAG[3:0] differs from n[3:0]; an error sets err_o and goes to DONE.
REQ-025 A good status goes to CMD for frame n+1 when frame_cnt_o<NUM_FRAMES, else to DONE.
REQ-026 DONE lasts exactly one cycle with done_o=1, then IDLE; busy_o=1 in DONE.
REQ-027 start_i asserted outside IDLE SHALL be ignored; status beats arriving outside STS are not accepted.
REQ-028 Simultaneous events: a command handshake and a data word can never share a cycle; start_i held high re-triggers a run the cycle after DONE.
REQ-029 Per frame at zero backpressure: 1 command cycle + FRAME_BYTES/4 data cycles + 1 or more status cycles.

Reset
REQ-030 On aresetn=0, asynchronously: state=IDLE; all tvalid, sts tready, busy_o, done_o and err_o =0; frame_cnt_o=0; counters=0; cmd/data tdata=0.
REQ-031 Reset mid-run abandons the run with no done_o; after release the block waits in IDLE for start_i.
REQ-032 Deassertion is applied synchronously to clk_in1 (two-stage release) so all state leaves reset on the same edge.

Verification
REQ-033 Defaults, tready=1, OKAY status with the matching tag one cycle after tlast -> 4 commands with SADDR 0x0,0x1000,0x2000,0x3000 and TAG 0..3; 4096 words 0..4095; tlast on words 1023, 2047, 3071, 4095; frame_cnt_o=4; one done_o; err_o=0.
REQ-034 Random tready on cmd/data (50%) -> identical data sequence and command words as REQ-033; no tdata change while stalled.
REQ-035 Status 8'h41 (SLVERR, tag 1) on frame 1 -> err_o=1, frame_cnt_o=2, done_o pulse, no third command.
REQ-036 Status 8'h83 (OKAY, wrong tag) on frame 0 -> err_o=1, frame_cnt_o=1, done_o, IDLE.
REQ-037 aresetn low during DATA of frame 2 -> all outputs at reset values immediately; new start_i gives a run restarting at SADDR=BASE_ADDR, tdata=0.
REQ-038 FRAME_BYTES=4, NUM_FRAMES=1 -> one command with BTT=4, one beat tdata=0 with tlast=1, done_o after status.

Source files
------------

// File: rtl/datamover_s2mm_feeder.sv
// S2MM DataMover feeder: issues one write command per frame, streams a run-wide
// incrementing word pattern, and checks each frame's status beat.
module datamover_s2mm_feeder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned FRAME_BYTES = 4096,
  parameter int unsigned NUM_FRAMES  = 4
) (
  input  logic        clk_in1,
  input  logic        aresetn,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] frame_cnt_o,
  output logic [71:0] m_axis_cmd_tdata,
  output logic        m_axis_cmd_tvalid,
  input  logic        m_axis_cmd_tready,
  output logic [31:0] m_axis_data_tdata,
  output logic [3:0]  m_axis_data_tkeep,
  output logic        m_axis_data_tlast,
  output logic        m_axis_data_tvalid,
  input  logic        m_axis_data_tready,
  input  logic [7:0]  s_axis_sts_tdata,
  input  logic        s_axis_sts_tvalid,
  output logic        s_axis_sts_tready
);

  typedef enum logic [2:0] {IDLE, CMD, DATA, STS, DONE} state_t;

  localparam logic [20:0] LAST_BEAT    = 21'(FRAME_BYTES / 4 - 1);
  localparam logic [16:0] NUM_FRAMES_W = 17'(NUM_FRAMES);
  localparam logic [31:0] FRAME_STRIDE = 32'(FRAME_BYTES);
  localparam logic [22:0] BTT          = 23'(FRAME_BYTES);

  // Reset asserts immediately but releases on a clock edge so all state leaves reset together.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_in1 or negedge aresetn) begin
    if (!aresetn) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  state_t      state_q, state_d;
  logic [3:0]  frame_idx_q, frame_idx_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [20:0] beat_cnt_q, beat_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] saddr_q, saddr_d;
  logic        err_q, err_d;
  logic        sts_bad;
  logic [16:0] frame_cnt_inc;

  always_ff @(posedge clk_in1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frame_idx_q <= '0;
      word_cnt_q  <= '0;
      beat_cnt_q  <= '0;
      frame_cnt_q <= '0;
      saddr_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_idx_q <= frame_idx_d;
      word_cnt_q  <= word_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      saddr_q     <= saddr_d;
      err_q       <= err_d;
    end
  end

  // Status is bad on missing OKAY, any error bit, or a tag that is not this frame's.
  assign sts_bad = !s_axis_sts_tdata[7] || (|s_axis_sts_tdata[6:4]) ||
                   (s_axis_sts_tdata[3:0] != frame_idx_q);
  assign frame_cnt_inc = {1'b0, frame_cnt_q} + 17'd1;

  always_comb begin
    state_d     = state_q;
    frame_idx_d = frame_idx_q;
    word_cnt_d  = word_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    frame_cnt_d = frame_cnt_q;
    saddr_d     = saddr_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = CMD;
          frame_idx_d = '0;
          word_cnt_d  = '0;
          beat_cnt_d  = '0;
          frame_cnt_d = '0;
          saddr_d     = BASE_ADDR;
          err_d       = 1'b0;
        end
      end
      CMD: begin
        if (m_axis_cmd_tready) begin
          state_d    = DATA;
          beat_cnt_d = '0;
        end
      end
      DATA: begin
        if (m_axis_data_tready) begin
          word_cnt_d = word_cnt_q + 32'd1;
          beat_cnt_d = beat_cnt_q + 21'd1;
          if (beat_cnt_q == LAST_BEAT) state_d = STS;
        end
      end
      STS: begin
        if (s_axis_sts_tvalid) begin
          frame_cnt_d = frame_cnt_inc[15:0];
          if (sts_bad) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (frame_cnt_inc < NUM_FRAMES_W) begin
            state_d     = CMD;
            frame_idx_d = frame_idx_q + 4'd1;
            saddr_d     = saddr_q + FRAME_STRIDE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o             = (state_q != IDLE);
  assign done_o             = (state_q == DONE);
  assign err_o              = err_q;
  assign frame_cnt_o        = frame_cnt_q;
  assign m_axis_cmd_tvalid  = (state_q == CMD);
  assign m_axis_cmd_tdata   = (state_q == CMD) ?
                              {4'h0, frame_idx_q, saddr_q, 1'b0, 1'b1, 6'h00, 1'b1, BTT} : 72'h0;
  assign m_axis_data_tvalid = (state_q == DATA);
  assign m_axis_data_tdata  = word_cnt_q;
  assign m_axis_data_tkeep  = 4'hF;
  assign m_axis_data_tlast  = (state_q == DATA) && (beat_cnt_q == LAST_BEAT);
  assign s_axis_sts_tready  = (state_q == STS);

endmodule

// File: tb/tb_datamover_s2mm_feeder.sv
// Scoreboard bench for datamover_s2mm_feeder: default 4x4096 configuration plus a
// single-beat 4-byte / 1-frame instance.
module tb_datamover_s2mm_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, busy, done, err;
  logic [15:0] frame_cnt;
  logic [71:0] cmd_tdata;
  logic        cmd_tvalid, cmd_tready;
  logic [31:0] d_tdata;
  logic [3:0]  d_tkeep;
  logic        d_tlast, d_tvalid, d_tready;
  logic [7:0]  sts_tdata;
  logic        sts_tvalid, sts_tready;

  logic        start_b, busy_b, done_b, err_b;
  logic [15:0] frame_cnt_b;
  logic [71:0] cmd_tdata_b;
  logic        cmd_tvalid_b, cmd_tready_b;
  logic [31:0] d_tdata_b;
  logic [3:0]  d_tkeep_b;
  logic        d_tlast_b, d_tvalid_b, d_tready_b;
  logic [7:0]  sts_tdata_b;
  logic        sts_tvalid_b, sts_tready_b;

  datamover_s2mm_feeder dut (
    .clk_in1(clk), .aresetn(rst_n), .start_i(start),
    .busy_o(busy), .done_o(done), .err_o(err), .frame_cnt_o(frame_cnt),
    .m_axis_cmd_tdata(cmd_tdata), .m_axis_cmd_tvalid(cmd_tvalid), .m_axis_cmd_tready(cmd_tready),
    .m_axis_data_tdata(d_tdata), .m_axis_data_tkeep(d_tkeep), .m_axis_data_tlast(d_tlast),
    .m_axis_data_tvalid(d_tvalid), .m_axis_data_tready(d_tready),
    .s_axis_sts_tdata(sts_tdata), .s_axis_sts_tvalid(sts_tvalid), .s_axis_sts_tready(sts_tready)
  );

  datamover_s2mm_feeder #(.BASE_ADDR(32'h0), .FRAME_BYTES(4), .NUM_FRAMES(1)) dut_b (
    .clk_in1(clk), .aresetn(rst_n), .start_i(start_b),
    .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .frame_cnt_o(frame_cnt_b),
    .m_axis_cmd_tdata(cmd_tdata_b), .m_axis_cmd_tvalid(cmd_tvalid_b), .m_axis_cmd_tready(cmd_tready_b),
    .m_axis_data_tdata(d_tdata_b), .m_axis_data_tkeep(d_tkeep_b), .m_axis_data_tlast(d_tlast_b),
    .m_axis_data_tvalid(d_tvalid_b), .m_axis_data_tready(d_tready_b),
    .s_axis_sts_tdata(sts_tdata_b), .s_axis_sts_tvalid(sts_tvalid_b), .s_axis_sts_tready(sts_tready_b)
  );

  int checks = 0;
  int failures = 0;

  logic [71:0] exp_cmd_q[$];
  logic [32:0] exp_data_q[$];
  logic [71:0] exp_cmd_b_q[$];
  logic [32:0] exp_data_b_q[$];

  int done_cnt = 0, done_b_cnt = 0, data_hs_cnt = 0;
  int tlast_cnt = 0, sts_cnt = 0;
  bit rand_ready = 0;
  int bad_frame = -1;
  logic [7:0] bad_sts = 8'h00;

  task automatic check_output(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected beats on every handshake and enforces hold-while-stalled.
  logic        cmd_stalled = 0, d_stalled = 0;
  logic [71:0] prev_cmd;
  logic [33:0] prev_d;
  logic [71:0] exp_c;
  logic [32:0] exp_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      cmd_stalled = 0;
      d_stalled   = 0;
    end else begin
      if (cmd_stalled) check_output("cmd_hold", cmd_tdata, prev_cmd);
      if (d_stalled)   check_output("data_hold", {38'h0, d_tvalid, d_tlast, d_tdata}, {38'h0, prev_d});
      cmd_stalled = cmd_tvalid && !cmd_tready;
      d_stalled   = d_tvalid && !d_tready;
      prev_cmd    = cmd_tdata;
      prev_d      = {d_tvalid, d_tlast, d_tdata};
      if (cmd_tvalid && d_tvalid) check_output("cmd_data_overlap", 72'h1, 72'h0);
      if (cmd_tvalid && cmd_tready) begin
        if (exp_cmd_q.size() == 0) check_output("cmd_unexpected", cmd_tdata, 72'h0 ^ {72{1'bx}});
        else begin
          exp_c = exp_cmd_q.pop_front();
          check_output("cmd_word", cmd_tdata, exp_c);
        end
      end
      if (d_tvalid && d_tready) begin
        data_hs_cnt++;
        if (exp_data_q.size() == 0) check_output("data_unexpected", {39'h0, d_tlast, d_tdata}, {72{1'bx}});
        else begin
          exp_d = exp_data_q.pop_front();
          check_output("data_word", {39'h0, d_tlast, d_tdata}, {39'h0, exp_d});
          check_output("data_tkeep", {68'h0, d_tkeep}, 72'hF);
        end
        if (d_tlast) tlast_cnt++;
      end
      if (sts_tvalid && sts_tready) sts_cnt++;
      if (done) done_cnt++;

      if (cmd_tvalid_b && cmd_tready_b) begin
        if (exp_cmd_b_q.size() == 0) check_output("b_cmd_unexpected", cmd_tdata_b, {72{1'bx}});
        else check_output("b_cmd_word", cmd_tdata_b, exp_cmd_b_q.pop_front());
      end
      if (d_tvalid_b && d_tready_b) begin
        if (exp_data_b_q.size() == 0) check_output("b_data_unexpected", {39'h0, d_tlast_b, d_tdata_b}, {72{1'bx}});
        else check_output("b_data_word", {39'h0, d_tlast_b, d_tdata_b}, {39'h0, exp_data_b_q.pop_front()});
      end
      if (done_b) done_b_cnt++;
    end
  end

  // Sink model: ready generation and one status beat presented the cycle after each tlast.
  int sts_frame = 0, tlast_used = 0, sts_used = 0;
  always @(posedge clk) begin
    #1;
    cmd_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    d_tready   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!rst_n || start) begin
      sts_tvalid = 1'b0;
      sts_frame  = 0;
    end
    if (sts_cnt != sts_used) begin
      sts_used   = sts_cnt;
      sts_tvalid = 1'b0;
      sts_frame++;
    end
    if (tlast_cnt != tlast_used) begin
      tlast_used = tlast_cnt;
      if (rst_n) begin
        sts_tvalid = 1'b1;
        sts_tdata  = (sts_frame == bad_frame) ? bad_sts : {4'h8, 4'(sts_frame)};
      end
    end
  end

  task automatic apply_stimulus(input int ncmd, input int nwords);
    exp_cmd_q.delete();
    exp_data_q.delete();
    for (int i = 0; i < ncmd; i++)
      exp_cmd_q.push_back({4'h0, 4'(i), 32'(i) * 32'h0000_1000, 32'h4080_1000});
    for (int k = 0; k < nwords; k++)
      exp_data_q.push_back({(k % 1024) == 1023, 32'(k)});
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_test(input string name, input int ncmd, input int nwords,
                          input logic exp_err, input logic [15:0] exp_fc);
    int base;
    base = done_cnt;
    apply_stimulus(ncmd, nwords);
    for (int c = 0; c < 30000 && done_cnt == base; c++) @(negedge clk);
    if (done_cnt == base) check_output({name, "_timeout"}, 72'h0, 72'h1);
    repeat (3) @(negedge clk);
    check_output({name, "_done_pulses"}, 72'(done_cnt - base), 72'd1);
    check_output({name, "_err"}, {71'h0, err}, {71'h0, exp_err});
    check_output({name, "_frame_cnt"}, {56'h0, frame_cnt}, {56'h0, exp_fc});
    check_output({name, "_busy_idle"}, {71'h0, busy}, 72'h0);
    check_output({name, "_cmd_left"}, 72'(exp_cmd_q.size()), 72'h0);
    check_output({name, "_data_left"}, 72'(exp_data_q.size()), 72'h0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_b = 1'b0;
    cmd_tready = 1'b1; d_tready = 1'b1; sts_tvalid = 1'b0; sts_tdata = 8'h00;
    cmd_tready_b = 1'b1; d_tready_b = 1'b1; sts_tvalid_b = 1'b0; sts_tdata_b = 8'h00;
    repeat (3) @(posedge clk); #1;
    check_output("rst_busy_done_err", {69'h0, busy, done, err}, 72'h0);
    check_output("rst_valids_ready", {69'h0, cmd_tvalid, d_tvalid, sts_tready}, 72'h0);
    check_output("rst_frame_cnt", {56'h0, frame_cnt}, 72'h0);
    check_output("rst_cmd_tdata", cmd_tdata, 72'h0);
    check_output("rst_data_tdata", {40'h0, d_tdata}, 72'h0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    run_test("normal", 4, 4096, 1'b0, 16'd4);

    rand_ready = 1;
    run_test("random_ready", 4, 4096, 1'b0, 16'd4);
    rand_ready = 0;

    bad_frame = 1; bad_sts = 8'h41;
    run_test("slverr_f1", 2, 2048, 1'b1, 16'd2);

    bad_frame = 0; bad_sts = 8'h83;
    run_test("bad_tag_f0", 1, 1024, 1'b1, 16'd1);
    bad_frame = -1;

    begin
      int base_done;
      int base_hs;
      base_done = done_cnt;
      base_hs   = data_hs_cnt;
      apply_stimulus(4, 4096);
      check_output("err_cleared_on_start", {71'h0, err}, 72'h0);
      for (int c = 0; c < 10000 && data_hs_cnt < base_hs + 2100; c++) @(negedge clk);
      if (data_hs_cnt < base_hs + 2100) check_output("midrun_timeout", 72'h0, 72'h1);
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      check_output("midrun_rst_flags", {69'h0, busy, done, err}, 72'h0);
      check_output("midrun_rst_valids", {69'h0, cmd_tvalid, d_tvalid, sts_tready}, 72'h0);
      check_output("midrun_rst_frame_cnt", {56'h0, frame_cnt}, 72'h0);
      check_output("midrun_rst_tdata", {40'h0, d_tdata}, 72'h0);
      repeat (3) @(posedge clk); #1 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check_output("midrun_no_done", 72'(done_cnt - base_done), 72'h0);
      check_output("midrun_idle_wait", {71'h0, busy}, 72'h0);
    end
    run_test("after_reset", 4, 4096, 1'b0, 16'd4);

    begin
      int base_b;
      base_b = done_b_cnt;
      exp_cmd_b_q.push_back(72'h00_0000_0000_4080_0004);
      exp_data_b_q.push_back({1'b1, 32'h0000_0000});
      @(posedge clk); #1 start_b = 1'b1;
      @(posedge clk); #1 start_b = 1'b0;
      for (int c = 0; c < 50 && !sts_tready_b; c++) @(negedge clk);
      check_output("b_sts_ready", {71'h0, sts_tready_b}, 72'h1);
      sts_tvalid_b = 1'b1; sts_tdata_b = 8'h80;
      @(posedge clk); #1 sts_tvalid_b = 1'b0;
      repeat (3) @(negedge clk);
      check_output("b_done_pulses", 72'(done_b_cnt - base_b), 72'd1);
      check_output("b_frame_cnt", {56'h0, frame_cnt_b}, 72'd1);
      check_output("b_err", {71'h0, err_b}, 72'h0);
      check_output("b_queues_left", 72'(exp_cmd_b_q.size() + exp_data_b_q.size()), 72'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
